// File: rtl/lfsr_pkg.sv
// Shared constants, FSM encoding and the range-mask helper for the LFSR random source.
package lfsr_pkg;

    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hB400;
    localparam logic [23:0] TAPS_W24 = 24'hE10000;
    localparam logic [31:0] TAPS_W32 = 32'h80200003;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        RESP = 2'd2
    } fsm_t;

    // Smallest all-ones mask covering bound-1; bound==0 stands for the full out_w-bit range.
    function automatic logic [31:0] range_mask(input logic [31:0] bound, input int out_w);
        logic [31:0] lim;
        logic [31:0] mask;
        mask = '0;
        lim  = bound - 32'd1;
        for (int i = 0; i < 32; i++) begin
            if (bound == 32'd0) begin
                if (i < out_w) mask[i] = 1'b1;
            end else if ((lim >> i) != 32'd0) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci shift register with run-time load and a guard that never lets the state rest at zero.
module lfsr_core #(
    parameter int              WIDTH      = 16,
    parameter logic [WIDTH-1:0] TAPS       = 16'hB400,
    parameter logic [WIDTH-1:0] RESET_SEED = 16'h0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state,
    output logic             zero_fix
);

    logic [WIDTH-1:0] state_q;
    logic             feedback;

    assign feedback = ^(state_q & TAPS);
    // Pulses on the edge that replaces a zero (loaded or resident) with 1.
    assign zero_fix = load ? (load_val == '0) : (state_q == '0);
    assign state    = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_SEED;
        end else if (load) begin
            state_q <= (load_val == '0) ? WIDTH'(1) : load_val;
        end else if (state_q == '0) begin
            state_q <= WIDTH'(1);
        end else if (step) begin
            state_q <= {state_q[WIDTH-2:0], feedback};
        end
    end

endmodule

// File: rtl/lfsr_range_rng.sv
// LFSR random source with a request/response service returning a uniform integer in [0,bound)
// by masked rejection sampling, with a deterministic fallback after MAX_TRIES rejections.
module lfsr_range_rng
    import lfsr_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] TAPS       = 16'hB400,
    parameter logic [WIDTH-1:0] RESET_SEED = 16'h0001,
    parameter int               OUT_W      = 8,
    parameter int               MAX_TRIES  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] seed,
    input  logic             seed_load,
    input  logic             enable,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OUT_W-1:0] bound,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [OUT_W-1:0] rsp_data,
    output logic             seed_zero,
    output logic [1:0]       dbg_state,
    output logic [WIDTH-1:0] dbg_lfsr
);

    localparam int             TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    fsm_t             state_q, state_d;
    logic [WIDTH-1:0] lfsr;
    logic             zero_fix;
    logic [OUT_W-1:0] bnd_q, mask_q, cand, rsp_q;
    logic [TRY_W-1:0] try_cnt;
    logic             start, take, fallback, retry;
    logic             seed_zero_q;

    lfsr_core #(
        .WIDTH      (WIDTH),
        .TAPS       (TAPS),
        .RESET_SEED (RESET_SEED)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .step     (enable | (state_q == DRAW)),
        .load     (seed_load),
        .load_val (seed),
        .state    (lfsr),
        .zero_fix (zero_fix)
    );

    assign cand = lfsr[OUT_W-1:0] & mask_q;

    // Handshakes: a transfer happens on an edge where valid and ready are both high.
    // req_ready is high only in IDLE; rsp_valid is high only in RESP and, once raised,
    // holds with rsp_data frozen until the edge on which rsp_ready is seen high.
    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        take     = 1'b0;
        fallback = 1'b0;
        retry    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    start   = 1'b1;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                if (bnd_q == '0 || cand < bnd_q) begin
                    take    = 1'b1;
                    state_d = RESP;
                end else if (try_cnt == LAST_TRY) begin
                    fallback = 1'b1;
                    state_d  = RESP;
                end else begin
                    retry = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bnd_q       <= '0;
            mask_q      <= '0;
            try_cnt     <= '0;
            rsp_q       <= '0;
            seed_zero_q <= 1'b0;
        end else begin
            seed_zero_q <= seed_zero_q | zero_fix;
            if (start) begin
                bnd_q   <= bound;
                mask_q  <= OUT_W'(range_mask(32'(bound), OUT_W));
                try_cnt <= '0;
            end
            if (retry)    try_cnt <= try_cnt + TRY_W'(1);
            if (take)     rsp_q   <= cand;
            // mask_q < 2*bnd_q, so a rejected cand lies in [bnd_q, 2*bnd_q) and this stays in range.
            if (fallback) rsp_q   <= cand - bnd_q;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_q;
    assign seed_zero = seed_zero_q;
    assign dbg_state = state_q;
    assign dbg_lfsr  = lfsr;

endmodule

// File: tb/tb_lfsr_range_rng.sv
// Self-checking bench for lfsr_range_rng: scenario tasks checked against a behavioural
// model of the LFSR sequence and of rejection sampling.
module tb_lfsr_range_rng;

    logic        clk = 1'b0;
    logic        rst, seed_load, enable, req_valid, rsp_ready;
    logic        ft_req_valid, ft_rsp_ready;
    logic [15:0] seed;
    logic [7:0]  bound;

    logic        req_ready, rsp_valid, seed_zero;
    logic [7:0]  rsp_data;
    logic [1:0]  dbg_state;
    logic [15:0] dbg_lfsr;
    logic        ft_req_ready, ft_rsp_valid, ft_seed_zero;
    logic [7:0]  ft_rsp_data;
    logic [1:0]  ft_dbg_state;
    logic [15:0] ft_dbg_lfsr;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] m_state;

    always #5 clk = ~clk;

    lfsr_range_rng dut (
        .clk(clk), .rst(rst), .seed(seed), .seed_load(seed_load), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready), .bound(bound),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .seed_zero(seed_zero), .dbg_state(dbg_state), .dbg_lfsr(dbg_lfsr)
    );

    lfsr_range_rng #(.MAX_TRIES(1)) dut_ft (
        .clk(clk), .rst(rst), .seed(seed), .seed_load(seed_load), .enable(enable),
        .req_valid(ft_req_valid), .req_ready(ft_req_ready), .bound(bound),
        .rsp_valid(ft_rsp_valid), .rsp_ready(ft_rsp_ready), .rsp_data(ft_rsp_data),
        .seed_zero(ft_seed_zero), .dbg_state(ft_dbg_state), .dbg_lfsr(ft_dbg_lfsr)
    );

    // ---------------- reference model ----------------
    function automatic logic [15:0] m_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic int m_mask(input int b);
        int p;
        if (b == 0) return 255;
        p = 1;
        while (p < b) p = p * 2;
        return p - 1;
    endfunction

    // One candidate per cycle from the current state; the state advances on every try.
    task automatic m_draw(input int b, input int max_tries, output int val, output int tries);
        int c;
        tries = 0;
        val   = 0;
        while (1) begin
            tries++;
            c       = int'(m_state[7:0]) & m_mask(b);
            m_state = m_step(m_state);
            if (b == 0 || c < b) begin
                val = c;
                return;
            end
            if (tries == max_tries) begin
                val = c - b;
                return;
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_seed(input logic [15:0] s);
        seed      = s;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        m_state   = (s == 16'h0) ? 16'h0001 : s;
    endtask

    task automatic drive_draw(input int b, output int lat, output logic [7:0] data);
        bound     = 8'(b);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        bound     = 8'($urandom_range(0, 255));
        lat       = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        data = rsp_data;
    endtask

    task automatic release_rsp;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({req_ready, rsp_valid, rsp_data, seed_zero, dbg_state, dbg_lfsr} !==
            {1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 16'h0001}) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%b vld=%b data=%0h sz=%b st=%0d lfsr=%0h required 1 0 0 0 0 0001",
                     req_ready, rsp_valid, rsp_data, seed_zero, dbg_state, dbg_lfsr);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (dbg_lfsr !== 16'h0001 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: got lfsr=%0h rdy=%b required 0001 1", dbg_lfsr, req_ready);
        end
    endtask

    task automatic test_step_period;
        int zeros = 0, mism = 0, early = 0;
        enable = 1'b0;
        load_seed(16'hACE1);
        n_checks++;
        if (dbg_lfsr !== 16'hACE1) begin
            n_fail++;
            $display("FAIL seed_load: got %0h required ace1", dbg_lfsr);
        end
        enable = 1'b1;
        tick();
        m_state = m_step(m_state);
        n_checks++;
        if (dbg_lfsr !== 16'h59C3) begin
            n_fail++;
            $display("FAIL first_step: got %0h required 59c3", dbg_lfsr);
        end
        for (int k = 2; k <= 65535; k++) begin
            tick();
            m_state = m_step(m_state);
            if (dbg_lfsr === 16'h0000) zeros++;
            if (dbg_lfsr !== m_state) mism++;
            if (k < 65535 && dbg_lfsr === 16'hACE1) early++;
        end
        enable = 1'b0;
        n_checks++;
        if (zeros != 0) begin
            n_fail++;
            $display("FAIL period_no_zero: got %0d zero states required 0", zeros);
        end
        n_checks++;
        if (mism != 0) begin
            n_fail++;
            $display("FAIL period_sequence: got %0d model differences required 0", mism);
        end
        n_checks++;
        if (early != 0) begin
            n_fail++;
            $display("FAIL period_early_repeat: got %0d early returns required 0", early);
        end
        n_checks++;
        if (dbg_lfsr !== 16'hACE1) begin
            n_fail++;
            $display("FAIL period_65535: got %0h required ace1", dbg_lfsr);
        end
    endtask

    task automatic test_rejection;
        int lat, ev, et;
        logic [7:0] d;
        enable = 1'b0;
        rsp_ready = 1'b0;
        load_seed(16'h0007);
        m_draw(5, 8, ev, et);
        drive_draw(5, lat, d);
        n_checks++;
        if (lat != 3 || et != 3) begin
            n_fail++;
            $display("FAIL reject_latency: got %0d edges after accept (model %0d) required 3", lat, et);
        end
        n_checks++;
        if (d !== 8'd4) begin
            n_fail++;
            $display("FAIL reject_data: got %0d required 4", d);
        end
        n_checks++;
        if (dbg_lfsr !== m_state) begin
            n_fail++;
            $display("FAIL reject_steps: got lfsr %0h required %0h", dbg_lfsr, m_state);
        end
        release_rsp();
    endtask

    task automatic test_fallback;
        enable = 1'b0;
        ft_rsp_ready = 1'b0;
        load_seed(16'h0007);
        bound = 8'd5;
        ft_req_valid = 1'b1;
        tick();
        ft_req_valid = 1'b0;
        n_checks++;
        if (ft_rsp_valid !== 1'b0 || ft_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fallback_draw: got vld=%b rdy=%b required 0 0", ft_rsp_valid, ft_req_ready);
        end
        tick();
        n_checks++;
        if (ft_rsp_valid !== 1'b1 || ft_rsp_data !== 8'd2) begin
            n_fail++;
            $display("FAIL fallback_data: got vld=%b data=%0d required 1 2", ft_rsp_valid, ft_rsp_data);
        end
        ft_rsp_ready = 1'b1;
        tick();
        ft_rsp_ready = 1'b0;
        n_checks++;
        if (ft_req_ready !== 1'b1 || ft_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fallback_release: got rdy=%b vld=%b required 1 0", ft_req_ready, ft_rsp_valid);
        end
    endtask

    task automatic test_edge_bounds;
        int lat, ev, et, b;
        logic [7:0]  d;
        logic [15:0] pre;
        int bad_data = 0, bad_lat = 0, bad_range = 0, bad_rel = 0;
        enable = 1'b0;
        rsp_ready = 1'b0;
        load_seed(16'($urandom_range(1, 65535)));
        m_draw(1, 8, ev, et);
        drive_draw(1, lat, d);
        n_checks++;
        if (d !== 8'd0 || lat != 1) begin
            n_fail++;
            $display("FAIL bound_one: got data=%0d lat=%0d required 0 1", d, lat);
        end
        release_rsp();
        pre = m_state;
        m_draw(0, 8, ev, et);
        drive_draw(0, lat, d);
        n_checks++;
        if (d !== pre[7:0] || lat != 1) begin
            n_fail++;
            $display("FAIL bound_zero: got data=%0h lat=%0d required %0h 1", d, lat, pre[7:0]);
        end
        release_rsp();
        for (int i = 0; i < 1000; i++) begin
            b = $urandom_range(0, 255);
            m_draw(b, 8, ev, et);
            drive_draw(b, lat, d);
            if (int'(d) != ev) bad_data++;
            if (lat != et) bad_lat++;
            if (b != 0 && int'(d) >= b) bad_range++;
            release_rsp();
            if (req_ready !== 1'b1 || rsp_valid !== 1'b0) bad_rel++;
        end
        n_checks++;
        if (bad_data != 0) begin
            n_fail++;
            $display("FAIL random_data: got %0d wrong values required 0", bad_data);
        end
        n_checks++;
        if (bad_lat != 0) begin
            n_fail++;
            $display("FAIL random_latency: got %0d wrong latencies required 0", bad_lat);
        end
        n_checks++;
        if (bad_range != 0) begin
            n_fail++;
            $display("FAIL random_range: got %0d values >= bound required 0", bad_range);
        end
        n_checks++;
        if (bad_rel != 0) begin
            n_fail++;
            $display("FAIL random_release: got %0d bad returns to idle required 0", bad_rel);
        end
    endtask

    task automatic test_handshake;
        int lat, ev, et, b, unstable = 0;
        logic [7:0] d;
        enable = 1'b0;
        rsp_ready = 1'b0;
        load_seed(16'($urandom_range(1, 65535)));
        b = $urandom_range(1, 255);
        m_draw(b, 8, ev, et);
        drive_draw(b, lat, d);
        n_checks++;
        if (int'(d) != ev || lat != et) begin
            n_fail++;
            $display("FAIL hold_first: got data=%0d lat=%0d required %0d %0d", d, lat, ev, et);
        end
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bound = 8'($urandom_range(0, 255));
            tick();
            if (rsp_valid !== 1'b1 || rsp_data !== d || req_ready !== 1'b0) unstable++;
        end
        req_valid = 1'b0;
        n_checks++;
        if (unstable != 0) begin
            n_fail++;
            $display("FAIL hold_stable: got %0d unstable cycles required 0", unstable);
        end
        n_checks++;
        if (dbg_lfsr !== m_state) begin
            n_fail++;
            $display("FAIL hold_no_step: got lfsr %0h required %0h", dbg_lfsr, m_state);
        end
        release_rsp();
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL hold_release: got rdy=%b vld=%b st=%0d required 1 0 0", req_ready, rsp_valid, dbg_state);
        end
    endtask

    task automatic test_zero_reset;
        int lat, stale = 0;
        logic [7:0] d;
        enable = 1'b0;
        rsp_ready = 1'b0;
        load_seed(16'h0000);
        n_checks++;
        if (dbg_lfsr !== 16'h0001 || seed_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_seed: got lfsr=%0h sz=%b required 0001 1", dbg_lfsr, seed_zero);
        end
        load_seed(16'h0007);
        n_checks++;
        if (seed_zero !== 1'b1 || dbg_lfsr !== 16'h0007) begin
            n_fail++;
            $display("FAIL zero_sticky: got sz=%b lfsr=%0h required 1 0007", seed_zero, dbg_lfsr);
        end
        drive_draw(5, lat, d);
        n_checks++;
        if (d !== 8'd4) begin
            n_fail++;
            $display("FAIL pre_reset_data: got %0d required 4", d);
        end
        release_rsp();
        bound = 8'd5;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_data, seed_zero, dbg_state, dbg_lfsr} !==
            {1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 16'h0001}) begin
            n_fail++;
            $display("FAIL async_reset: got rdy=%b vld=%b data=%0d sz=%b st=%0d lfsr=%0h required 1 0 0 0 0 0001",
                     req_ready, rsp_valid, rsp_data, seed_zero, dbg_state, dbg_lfsr);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) stale++;
        end
        n_checks++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL no_stale_rsp: got %0d cycles with response state required 0", stale);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        seed = 16'h0;
        seed_load = 1'b0;
        enable = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        bound = 8'd0;
        ft_req_valid = 1'b0;
        ft_rsp_ready = 1'b0;
        test_reset();
        test_step_period();
        test_rejection();
        test_fallback();
        test_edge_bounds();
        test_handshake();
        test_zero_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
